// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer
// Runs one two-layer inference (N_IN -> N_HID -> N_OUT) on a shared MAC. For
// each neuron it walks the fan-in addresses, pulses mac_clr/mac_en one cycle
// behind the addresses (1-cycle memory latency), then either writes a
// ReLU/saturated hidden value (layer 0) or runs a running argmax (layer 1).
// Optional feature macro: MNIST_PERF_CNT_EN. When defined, a saturating busy-cycle
// counter latches the total inference latency into perf_cycles on completion.
// When undefined, perf_cycles is tied to 0.
module mnist_infer_sequencer #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 16,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int FRAC   = 8
) (
  input  logic                                        ACLK,
  input  logic                                        ARESET,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic                                        irq_ack,
  input  logic signed [ACC_W-1:0]                     acc,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        irq,
  output logic [$clog2(N_IN)-1:0]                     in_addr,
  output logic [$clog2(N_IN*N_HID+N_HID*N_OUT)-1:0]   w_addr,
  output logic [$clog2(N_HID+N_OUT)-1:0]              b_addr,
  output logic [$clog2(N_HID)-1:0]                    hid_addr,
  output logic                                        hid_we,
  output logic [DATA_W-1:0]                           hid_wdata,
  output logic                                        mac_clr,
  output logic                                        mac_en,
  output logic [$clog2(N_OUT)-1:0]                    class_out,
  output logic signed [ACC_W-1:0]                     class_score,
  output logic [31:0]                                 perf_cycles
);

  // Address / counter widths
  localparam int IN_W  = $clog2(N_IN);
  localparam int W_W   = $clog2(N_IN*N_HID + N_HID*N_OUT);
  localparam int B_W   = $clog2(N_HID + N_OUT);
  localparam int HID_W = $clog2(N_HID);
  localparam int CLS_W = $clog2(N_OUT);
  // Fan-in index must cover the larger of the two layer fan-ins
  localparam int I_W   = $clog2((N_IN > N_HID) ? N_IN : N_HID);
  // Neuron index must cover the larger of the two layer widths
  localparam int N_W   = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);

  // Largest positive value representable in a signed DATA_W hidden word
  localparam logic signed [ACC_W-1:0] HID_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  // FSM encoding
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_L0_ADDR  = 3'd1;
  localparam logic [2:0] S_L0_DRAIN = 3'd2;
  localparam logic [2:0] S_L0_WB    = 3'd3;
  localparam logic [2:0] S_L1_ADDR  = 3'd4;
  localparam logic [2:0] S_L1_DRAIN = 3'd5;
  localparam logic [2:0] S_L1_CMP   = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  logic [2:0]              state_reg;
  logic [2:0]              state_next;
  logic [I_W-1:0]          i_reg;
  logic [N_W-1:0]          n_reg;
  logic [W_W-1:0]          w_cnt_reg;
  logic                    mac_en_reg;
  logic                    mac_clr_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    irq_reg;
  logic signed [ACC_W-1:0] best_val_reg;
  logic [CLS_W-1:0]        best_idx_reg;
  logic [CLS_W-1:0]        class_reg;
  logic signed [ACC_W-1:0] score_reg;

  logic                    i_last_l0;
  logic                    i_last_l1;
  logic                    n_last_l0;
  logic                    n_last_l1;
  logic                    abort_hit;
  logic signed [ACC_W-1:0] acc_shift;
  logic [DATA_W-1:0]       hid_sat;

  assign i_last_l0 = (i_reg == I_W'(N_IN - 1));
  assign i_last_l1 = (i_reg == I_W'(N_HID - 1));
  assign n_last_l0 = (n_reg == N_W'(N_HID - 1));
  assign n_last_l1 = (n_reg == N_W'(N_OUT - 1));
  // Abort only matters while an inference is in flight
  assign abort_hit = abort && (state_reg != S_IDLE);

  assign acc_shift = acc >>> FRAC;

  // ReLU then clamp to the positive range of a signed hidden word
  always_comb begin
    hid_sat = acc_shift[DATA_W-1:0];
    if (acc_shift[ACC_W-1]) begin
      hid_sat = '0;
    end else if (acc_shift > HID_MAX) begin
      hid_sat = HID_MAX[DATA_W-1:0];
    end
  end

  // Next-state logic; abort overrides every in-flight transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_L0_ADDR;
      S_L0_ADDR:  if (i_last_l0) state_next = S_L0_DRAIN;
      S_L0_DRAIN: state_next = S_L0_WB;
      S_L0_WB:    state_next = n_last_l0 ? S_L1_ADDR : S_L0_ADDR;
      S_L1_ADDR:  if (i_last_l1) state_next = S_L1_DRAIN;
      S_L1_DRAIN: state_next = S_L1_CMP;
      S_L1_CMP:   state_next = n_last_l1 ? S_FIN : S_L1_ADDR;
      S_FIN:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (abort_hit) begin
      state_next = S_IDLE;
    end
  end

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address walk and MAC strobes; strobes trail the address by one cycle
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      i_reg       <= '0;
      n_reg       <= '0;
      w_cnt_reg   <= '0;
      mac_en_reg  <= 1'b0;
      mac_clr_reg <= 1'b0;
    end else begin
      mac_en_reg  <= 1'b0;
      mac_clr_reg <= 1'b0;
      if (!abort_hit) begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              i_reg     <= '0;
              n_reg     <= '0;
              w_cnt_reg <= '0;
            end
          end
          S_L0_ADDR: begin
            mac_en_reg  <= 1'b1;
            mac_clr_reg <= (i_reg == '0);
            w_cnt_reg   <= w_cnt_reg + W_W'(1);
            i_reg       <= i_last_l0 ? '0 : i_reg + I_W'(1);
          end
          S_L0_WB: begin
            n_reg <= n_last_l0 ? '0 : n_reg + N_W'(1);
          end
          S_L1_ADDR: begin
            mac_en_reg  <= 1'b1;
            mac_clr_reg <= (i_reg == '0);
            // Hold on the final weight so w_addr never wraps after the run
            if (!(i_last_l1 && n_last_l1)) begin
              w_cnt_reg <= w_cnt_reg + W_W'(1);
            end
            i_reg <= i_last_l1 ? '0 : i_reg + I_W'(1);
          end
          S_L1_CMP: begin
            if (!n_last_l1) begin
              n_reg <= n_reg + N_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Running argmax over the output layer and completion handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
      class_reg    <= '0;
      score_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      if (abort_hit) begin
        busy_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              busy_reg <= 1'b1;
            end
          end
          S_L1_CMP: begin
            // Strict greater-than keeps the lowest index on ties
            if ((n_reg == '0) || (acc > best_val_reg)) begin
              best_val_reg <= acc;
              best_idx_reg <= CLS_W'(n_reg);
            end
          end
          S_FIN: begin
            class_reg <= best_idx_reg;
            score_reg <= best_val_reg;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky interrupt: completion wins over a same-cycle acknowledge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_reg <= 1'b0;
    end else if ((state_reg == S_FIN) && !abort_hit) begin
      irq_reg <= 1'b1;
    end else if (irq_ack) begin
      irq_reg <= 1'b0;
    end
  end

  // Memory addresses and hidden-buffer write port decoded from the FSM
  always_comb begin
    in_addr   = '0;
    b_addr    = '0;
    hid_addr  = '0;
    hid_we    = 1'b0;
    hid_wdata = '0;
    case (state_reg)
      S_L0_ADDR: begin
        in_addr = IN_W'(i_reg);
        b_addr  = B_W'(n_reg);
      end
      S_L0_DRAIN: begin
        b_addr = B_W'(n_reg);
      end
      S_L0_WB: begin
        b_addr    = B_W'(n_reg);
        hid_addr  = HID_W'(n_reg);
        hid_we    = 1'b1;
        hid_wdata = hid_sat;
      end
      S_L1_ADDR: begin
        b_addr   = B_W'(N_HID) + B_W'(n_reg);
        hid_addr = HID_W'(i_reg);
      end
      S_L1_DRAIN, S_L1_CMP: begin
        b_addr = B_W'(N_HID) + B_W'(n_reg);
      end
      default: ;
    endcase
  end

  assign w_addr      = w_cnt_reg;
  assign mac_en      = mac_en_reg;
  assign mac_clr     = mac_clr_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign irq         = irq_reg;
  assign class_out   = class_reg;
  assign class_score = score_reg;

`ifdef MNIST_PERF_CNT_EN
  logic [31:0] perf_cnt_reg;
  logic [31:0] perf_cycles_reg;

  // Saturating busy-cycle counter; the completion cycle itself adds one
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      perf_cnt_reg    <= '0;
      perf_cycles_reg <= '0;
    end else begin
      if ((state_reg == S_IDLE) && start) begin
        perf_cnt_reg <= '0;
      end else if (busy_reg && (perf_cnt_reg != '1)) begin
        perf_cnt_reg <= perf_cnt_reg + 32'd1;
      end
      if ((state_reg == S_FIN) && !abort_hit) begin
        perf_cycles_reg <= (perf_cnt_reg == '1) ? perf_cnt_reg : perf_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_reg;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// tb_mnist_infer_sequencer
// Drives the sequencer with behavioural pixel/weight/bias/hidden memories and
// a behavioural MAC, and compares against a reference that evaluates the
// two-layer network directly with plain arithmetic.
module tb_mnist_infer_sequencer;

  localparam int N_IN   = 4;
  localparam int N_HID  = 3;
  localparam int N_OUT  = 2;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int FRAC   = 0;
  localparam int N_W0   = N_IN * N_HID;
  localparam int NW     = N_W0 + N_HID * N_OUT;
  localparam int NB     = N_HID + N_OUT;
  localparam int LAT    = 1 + N_HID * (N_IN + 2) + N_OUT * (N_HID + 2);
  localparam longint HMAX = (64'sd1 <<< (DATA_W - 1)) - 1;

  logic                               ACLK    = 1'b0;
  logic                               ARESET  = 1'b0;
  logic                               start   = 1'b0;
  logic                               abort   = 1'b0;
  logic                               irq_ack = 1'b0;
  logic signed [ACC_W-1:0]            acc     = '0;
  logic                               busy, done, irq, hid_we, mac_clr, mac_en;
  logic [$clog2(N_IN)-1:0]            in_addr;
  logic [$clog2(NW)-1:0]              w_addr;
  logic [$clog2(NB)-1:0]              b_addr;
  logic [$clog2(N_HID)-1:0]           hid_addr;
  logic [DATA_W-1:0]                  hid_wdata;
  logic [$clog2(N_OUT)-1:0]           class_out;
  logic signed [ACC_W-1:0]            class_score;
  logic [31:0]                        perf_cycles;

  mnist_infer_sequencer #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT),
    .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC(FRAC)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort), .irq_ack(irq_ack),
    .acc(acc), .busy(busy), .done(done), .irq(irq), .in_addr(in_addr),
    .w_addr(w_addr), .b_addr(b_addr), .hid_addr(hid_addr), .hid_we(hid_we),
    .hid_wdata(hid_wdata), .mac_clr(mac_clr), .mac_en(mac_en),
    .class_out(class_out), .class_score(class_score), .perf_cycles(perf_cycles)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Behavioural memories and reference results
  int     pix[N_IN];
  int     wrom[NW];
  int     brom[NB];
  int     hid_mem[N_HID];
  longint ref_hid[N_HID];
  int     ref_class;
  longint ref_score;

  // Behavioural MAC / memory output registers
  longint w_q, x_q, b_q, acc_m;

  // Run bookkeeping
  int cyc = 0;
  int start_edge, j_exp, hid_cnt, done_cnt, done_lat, busy_low, run_id;
  bit run_on = 1'b0;
  logic [$clog2(NW)-1:0]    pw;
  logic [$clog2(N_IN)-1:0]  pin;
  logic [$clog2(N_HID)-1:0] phid;
  logic [$clog2(NB)-1:0]    pb;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint relu_sat(input longint a);
    longint s;
    s = a >>> FRAC;
    if (s < 0) return 0;
    if (s > HMAX) return HMAX;
    return s;
  endfunction

  // Direct evaluation of the network from the memory contents
  task automatic compute_ref();
    longint sum;
    for (int n = 0; n < N_HID; n++) begin
      sum = brom[n];
      for (int i = 0; i < N_IN; i++) sum += longint'(wrom[n*N_IN + i]) * pix[i];
      ref_hid[n] = relu_sat(sum);
    end
    for (int c = 0; c < N_OUT; c++) begin
      sum = brom[N_HID + c];
      for (int j = 0; j < N_HID; j++) sum += longint'(wrom[N_W0 + c*N_HID + j]) * ref_hid[j];
      if (c == 0 || sum > ref_score) begin
        ref_score = sum;
        ref_class = c;
      end
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N_IN; i++) pix[i] = int'($urandom_range(0, 63));
    for (int k = 0; k < NW; k++) wrom[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < NB; k++) brom[k] = int'($urandom_range(0, 40000)) - 20000;
  endtask

  // Zero pixels so each hidden value is its bias; zero L1 weights so outputs are biases
  task automatic load_directed(input int s0, input int s1);
    for (int i = 0; i < N_IN; i++) pix[i] = 0;
    for (int k = 0; k < NW; k++) wrom[k] = (k < N_W0) ? int'($urandom_range(0, 255)) - 128 : 0;
    brom[0] = -7;
    brom[1] = 40000;
    brom[2] = 123;
    brom[3] = s0;
    brom[4] = s1;
  endtask

  task automatic model_reset();
    w_q = 0; x_q = 0; b_q = 0; acc_m = 0;
    acc = '0;
  endtask

  // One clock: observe at the falling edge, update models just after the rising edge
  task automatic step();
    longint acc_n, wq_n, xq_n, bq_n, wd;
    bit wr, first;
    int wa, jj;
    @(negedge ACLK);
    if (run_on) begin
      if (mac_en) begin
        if (j_exp < NW) begin
          check("w_addr", pw, j_exp);
          if (j_exp < N_W0) begin
            first = (j_exp % N_IN) == 0;
            check("in_addr", pin, j_exp % N_IN);
            if (mac_clr) check("b_addr_l0", pb, j_exp / N_IN);
          end else begin
            jj = j_exp - N_W0;
            first = (jj % N_HID) == 0;
            check("hid_addr_rd", phid, jj % N_HID);
            if (mac_clr) check("b_addr_l1", pb, N_HID + jj / N_HID);
          end
          check("mac_clr", mac_clr, first);
        end else begin
          check("mac_en_extra", j_exp, NW - 1);
        end
        j_exp++;
      end else if (mac_clr) begin
        check("mac_clr_alone", mac_clr, 0);
      end
      if (hid_we) begin
        if (hid_cnt < N_HID) begin
          check("hid_addr_wr", hid_addr, hid_cnt);
          check("hid_wdata", hid_wdata, ref_hid[hid_cnt]);
        end else begin
          check("hid_we_extra", hid_cnt, N_HID - 1);
        end
        hid_cnt++;
      end
      if (done_cnt == 0 && cyc >= start_edge && !done && !busy) busy_low++;
      if (done) begin
        done_cnt++;
        done_lat = cyc - start_edge;
        check("busy_at_done", busy, 0);
        check("irq_at_done", irq, 1);
      end
    end
    pw = w_addr; pin = in_addr; phid = hid_addr; pb = b_addr;
    wq_n = (int'(w_addr) < NW) ? longint'(wrom[w_addr]) : 0;
    bq_n = (int'(b_addr) < NB) ? longint'(brom[b_addr]) : 0;
    if (int'(b_addr) >= N_HID)
      xq_n = (int'(hid_addr) < N_HID) ? longint'(hid_mem[hid_addr]) : 0;
    else
      xq_n = longint'(pix[in_addr]);
    if (mac_clr)     acc_n = b_q + w_q * x_q;
    else if (mac_en) acc_n = acc_m + w_q * x_q;
    else             acc_n = acc_m;
    wr = hid_we; wa = int'(hid_addr); wd = longint'(hid_wdata);
    @(posedge ACLK);
    cyc++;
    #1;
    w_q = wq_n; x_q = xq_n; b_q = bq_n; acc_m = acc_n;
    acc = ACC_W'(acc_m);
    if (wr && wa < N_HID) hid_mem[wa] = int'(wd);
  endtask

  task automatic begin_run();
    compute_ref();
    j_exp = 0; hid_cnt = 0; done_cnt = 0; done_lat = -1; busy_low = 0;
    run_on = 1'b1;
    start_edge = cyc + 1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  // Full inference; optionally re-pulse start mid-run and/or hold irq_ack throughout
  task automatic run_inf(input bit restart, input bit hold_ack);
    irq_ack = hold_ack;
    begin_run();
    for (int k = 0; k < LAT + 20 && done_cnt == 0; k++) begin
      if (restart && cyc == start_edge + 10) start = 1'b1;
      step();
      start = 1'b0;
    end
    repeat (3) step();
    run_on = 1'b0;
    check("done_once", done_cnt, 1);
    check("latency", done_lat, LAT);
    check("busy_during", busy_low, 0);
    check("mac_terms", j_exp, NW);
    check("hid_writes", hid_cnt, N_HID);
    check("class_out", class_out, ref_class);
    check("class_score", class_score, ref_score);
    check("irq_after", irq, hold_ack ? 0 : 1);
`ifdef MNIST_PERF_CNT_EN
    check("perf_cycles", perf_cycles, LAT);
`else
    check("perf_cycles", perf_cycles, 0);
`endif
    irq_ack = 1'b0;
    run_id++;
    $display("run %0d latency %0d class %0d score %0d", run_id, done_lat, class_out, class_score);
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("irq_clear", irq, 0);
  endtask

  logic [$clog2(N_OUT)-1:0] prev_cls;
  logic signed [ACC_W-1:0]  prev_score;
  logic [31:0]              prev_perf;

  initial begin
    run_id = 0;
    model_reset();
    #1 ARESET = 1'b1;
    #2;
    check("rst_outs", {busy, done, irq, hid_we, mac_en, mac_clr, in_addr, w_addr,
                       b_addr, hid_addr, hid_wdata, class_out}, 0);
    check("rst_score", class_score, 0);
    check("rst_perf", perf_cycles, 0);
    step();
    step();
    ARESET = 1'b0;
    step();

    // Directed: ReLU/saturation cases and tie -> lowest index
    load_directed(5, 5);
    run_inf(1'b0, 1'b0);
    check("dir_tie_class", class_out, 0);
    check("dir_tie_score", class_score, 5);
    repeat (3) step();
    check("irq_sticky", irq, 1);
    ack_irq();

    // Directed: second class wins; acknowledge held across completion
    load_directed(-3, 9);
    run_inf(1'b0, 1'b1);
    check("dir_cls1_class", class_out, 1);
    check("dir_cls1_score", class_score, 9);

    // Randomized networks; one with an ignored mid-run start
    for (int r = 0; r < 4; r++) begin
      load_random();
      run_inf(r == 1, 1'b0);
      ack_irq();
    end

    // Abort at cycle 10 of a run
    load_random();
    prev_cls = class_out; prev_score = class_score; prev_perf = perf_cycles;
    begin_run();
    while (cyc < start_edge + 10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_mac_en", mac_en, 0);
    check("abort_hid_we", hid_we, 0);
    repeat (40) step();
    run_on = 1'b0;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_irq", irq, 0);
    check("abort_class", class_out, prev_cls);
    check("abort_score", class_score, prev_score);
    check("abort_perf", perf_cycles, prev_perf);
    $display("run abort at cycle 10 class %0d", class_out);

    // Abort while idle does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle_busy", busy, 0);

    // Asynchronous reset mid-run, then a fresh inference
    load_random();
    begin_run();
    while (cyc < start_edge + 15) step();
    #2 ARESET = 1'b1;
    #1;
    check("arst_outs", {busy, done, irq, hid_we, mac_en, mac_clr, in_addr, w_addr,
                        b_addr, hid_addr, hid_wdata, class_out}, 0);
    check("arst_score", class_score, 0);
    check("arst_perf", perf_cycles, 0);
    run_on = 1'b0;
    step();
    step();
    ARESET = 1'b0;
    model_reset();
    step();
    $display("run reset at cycle 15");
    load_random();
    run_inf(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
